assoc_sequencer: RTL and testbench

ASSOC_SEQUENCER -- requirements
Module: assoc_sequencer

---
 rtl/assoc_pkg.sv | 22 ++
 rtl/assoc_argmax.sv | 45 ++++
 rtl/assoc_sequencer.sv | 157 +++++++++++++++
 tb/tb_assoc_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_pkg.sv
// Shared definitions for the associative-memory classification sequencer.
// Holds the FSM state encoding, the chunk index width and the default
// score width, plus a helper that sizes class-address fields.
package assoc_pkg;

  localparam int unsigned CHUNK_IDX_W     = 4;
  localparam int unsigned SCORE_W_DEFAULT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Width of a class address; at least one bit even for a single class.
  function automatic int unsigned cls_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/assoc_argmax.sv
// Running arg-max over per-class scores.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   clear       zero best_score/pred_class (new classification accepted)
//   update      score/cls present a complete class score this cycle
//   score       complete score of class cls
//   cls         class index of score
//   pred_class  index of the best class seen so far
//   best_score  best score seen so far
// The first class always wins; later classes win only on a strictly greater
// score, so ties keep the lower class index.
module assoc_argmax
  import assoc_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEFAULT,
  parameter int unsigned CLS_W   = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               update,
  input  logic [SCORE_W-1:0] score,
  input  logic [CLS_W-1:0]   cls,
  output logic [CLS_W-1:0]   pred_class,
  output logic [SCORE_W-1:0] best_score
);

  logic take;

  assign take = update && ((cls == '0) || (score > best_score));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pred_class <= '0;
      best_score <= '0;
    end else if (clear) begin
      pred_class <= '0;
      best_score <= '0;
    end else if (take) begin
      pred_class <= cls;
      best_score <= score;
    end
  end

endmodule

// File: rtl/assoc_sequencer.sv
// Classification sequencer: streams every chunk of every class hypervector
// out of chunk memory into an external accumulator, then keeps the arg-max
// of the per-class scores.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start            begin a classification (honoured only when idle)
//   abort            synchronous cancel, no done pulse
//   busy, done       status; done is a one-cycle completion pulse
//   rd_en/rd_class/rd_chunk   chunk-memory read request and address
//   acc_en/chunk_idx          accumulator controls (read pipeline delayed once)
//   score_in         accumulator result
//   pred_class, best_score    winning class and its score
// Optional feature (macro ASSOC_SEQ_THRESH_EN): min_score input and reject
// output, reject = final best_score < min_score, registered with done.
module assoc_sequencer
  import assoc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned NUM_CHUNKS  = 16,
  parameter int unsigned SCORE_W     = SCORE_W_DEFAULT
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              rd_en,
  output logic [cls_width(NUM_CLASSES)-1:0] rd_class,
  output logic [CHUNK_IDX_W-1:0]            rd_chunk,
  output logic                              acc_en,
  output logic [CHUNK_IDX_W-1:0]            chunk_idx,
  input  logic [SCORE_W-1:0]                score_in,
  output logic [cls_width(NUM_CLASSES)-1:0] pred_class,
  output logic [SCORE_W-1:0]                best_score
`ifdef ASSOC_SEQ_THRESH_EN
  ,
  input  logic [SCORE_W-1:0]                min_score,
  output logic                              reject
`endif
);

  localparam int unsigned CLS_W = cls_width(NUM_CLASSES);
  localparam logic [CLS_W-1:0]       LAST_CLS   = CLS_W'(NUM_CLASSES - 1);
  localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NUM_CHUNKS - 1);

  state_t state;
  logic   accept;
  logic   cmp_update;

  // abort wins over start even when idle.
  assign accept     = (state == ST_IDLE) && start && !abort;
  assign cmp_update = (state == ST_COMPARE) && !abort;

  // rd_class and rd_chunk are themselves the class and chunk counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_class  <= '0;
      rd_chunk  <= '0;
      acc_en    <= 1'b0;
      chunk_idx <= '0;
    end else begin
      // One-cycle memory latency: accumulator controls trail the read.
      acc_en    <= rd_en;
      chunk_idx <= rd_chunk;
      done      <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        rd_en    <= 1'b0;
        acc_en   <= 1'b0;
        rd_class <= '0;
        rd_chunk <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept) begin
              state    <= ST_FETCH;
              busy     <= 1'b1;
              rd_en    <= 1'b1;
              rd_class <= '0;
              rd_chunk <= '0;
            end
          end
          ST_FETCH: begin
            if (rd_chunk == LAST_CHUNK) begin
              state    <= ST_DRAIN;
              rd_en    <= 1'b0;
              rd_chunk <= '0;
            end else begin
              rd_chunk <= rd_chunk + CHUNK_IDX_W'(1);
            end
          end
          ST_DRAIN: begin
            state <= ST_COMPARE;
          end
          ST_COMPARE: begin
            if (rd_class == LAST_CLS) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              rd_class <= '0;
            end else begin
              state    <= ST_FETCH;
              rd_en    <= 1'b1;
              rd_class <= rd_class + CLS_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assoc_argmax #(
    .SCORE_W (SCORE_W),
    .CLS_W   (CLS_W)
  ) u_argmax (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (accept),
    .update     (cmp_update),
    .score      (score_in),
    .cls        (rd_class),
    .pred_class (pred_class),
    .best_score (best_score)
  );

`ifdef ASSOC_SEQ_THRESH_EN
  // Best score as it will be after this COMPARE cycle's arg-max update.
  logic [SCORE_W-1:0] final_best;

  assign final_best = ((rd_class == '0) || (score_in > best_score)) ? score_in : best_score;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reject <= 1'b0;
    end else if (accept) begin
      reject <= 1'b0;
    end else if (cmp_update && (rd_class == LAST_CLS)) begin
      reject <= (final_best < min_score);
    end
  end
`endif

endmodule

// File: tb/tb_assoc_sequencer.sv
module tb_assoc_sequencer;

  localparam int NC  = 3;
  localparam int NCH = 4;
  localparam int SW  = 7;
  localparam int T   = NC * (NCH + 2);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, rd_en, acc_en;
  logic [1:0]    rd_class, pred_class;
  logic [3:0]    rd_chunk, chunk_idx;
  logic [SW-1:0] score_in, best_score;
`ifdef ASSOC_SEQ_THRESH_EN
  logic [SW-1:0] min_score = '0;
  logic          reject;
`endif

  int checks = 0;
  int failures = 0;

  // Chunk memory contents and environment accumulator.
  int          mem [NC][NCH];
  logic [SW-1:0] acc;
  logic [1:0]  cls_d;

  assign score_in = acc;

  always #5 clk = ~clk;

  assoc_sequencer #(
    .NUM_CLASSES (NC),
    .NUM_CHUNKS  (NCH),
    .SCORE_W     (SW)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_class   (rd_class),
    .rd_chunk   (rd_chunk),
    .acc_en     (acc_en),
    .chunk_idx  (chunk_idx),
    .score_in   (score_in),
    .pred_class (pred_class),
    .best_score (best_score)
`ifdef ASSOC_SEQ_THRESH_EN
    ,
    .min_score  (min_score),
    .reject     (reject)
`endif
  );

  // Memory answers one cycle after the read; accumulator restarts on index 0.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc   <= '0;
      cls_d <= '0;
    end else begin
      cls_d <= rd_class;
      if (acc_en)
        acc <= ((chunk_idx == 4'd0) ? SW'(0) : acc) + SW'(mem[int'(cls_d)][int'(chunk_idx)]);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int class_sum(input int c);
    int s = 0;
    for (int j = 0; j < NCH; j++) s += mem[c][j];
    return s;
  endfunction

  // Arg-max over the first k classes: first wins, then strictly greater.
  function automatic void ref_best(input int k, output int p, output int b);
    p = 0;
    b = 0;
    for (int i = 0; i < k; i++) begin
      if (i == 0 || class_sum(i) > b) begin
        p = i;
        b = class_sum(i);
      end
    end
  endfunction

  // One classification. abort_at / restart_at: cycle index n (counted from
  // the edge that samples start) after which abort / start is driven; -1 = none.
  task automatic run_once(input int abort_at, input int restart_at, input int min_s);
    int  p, b, k, cyc, cl;
    bit  aborted;
    aborted = 0;
`ifdef ASSOC_SEQ_THRESH_EN
    min_score = SW'(min_s);
`endif
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n <= T + 2; n++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (aborted) begin
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_acc_en", int'(acc_en), 0);
        if (n == abort_at + 1) begin
          k = 0;
          for (int i = 0; i < NC; i++) if (6 * i + 6 <= abort_at) k++;
          ref_best(k, p, b);
          check("abort_pred", int'(pred_class), p);
          check("abort_best", int'(best_score), b);
        end
      end else if (n < T) begin
        cyc = n % (NCH + 2);
        cl  = n / (NCH + 2);
        check("busy", int'(busy), 1);
        check("done_low", int'(done), 0);
        check("rd_en", int'(rd_en), (cyc < NCH) ? 1 : 0);
        if (cyc < NCH) begin
          check("rd_chunk", int'(rd_chunk), cyc);
          check("rd_class", int'(rd_class), cl);
        end
        cyc = (n - 1) % (NCH + 2);
        check("acc_en", int'(acc_en), (n >= 1 && cyc < NCH) ? 1 : 0);
        if (n >= 1 && cyc < NCH) check("chunk_idx", int'(chunk_idx), cyc);
        if (n == 0) begin
          check("clear_pred", int'(pred_class), 0);
          check("clear_best", int'(best_score), 0);
`ifdef ASSOC_SEQ_THRESH_EN
          check("clear_reject", int'(reject), 0);
`endif
        end
      end else if (n == T) begin
        ref_best(NC, p, b);
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 1);
        check("pred_class", int'(pred_class), p);
        check("best_score", int'(best_score), b);
`ifdef ASSOC_SEQ_THRESH_EN
        check("reject", int'(reject), (b < min_s) ? 1 : 0);
`endif
      end else begin
        ref_best(NC, p, b);
        check("post_busy", int'(busy), 0);
        check("post_done", int'(done), 0);
        check("hold_pred", int'(pred_class), p);
        check("hold_best", int'(best_score), b);
      end
      if (!aborted && n == abort_at) begin
        abort = 1'b1;
        aborted = 1;
      end
      if (n == restart_at) start = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic set_rows(input int r0 [NCH], input int r1 [NCH], input int r2 [NCH]);
    for (int j = 0; j < NCH; j++) begin
      mem[0][j] = r0[j];
      mem[1][j] = r1[j];
      mem[2][j] = r2[j];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p, b;
    set_rows('{5, 0, 0, 0}, '{2, 3, 4, 0}, '{1, 1, 0, 0});
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_pred", int'(pred_class), 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Scores 5, 9, 2; a start pulse mid-run and one in DONE are ignored.
    run_once(-1, 3, 10);
    run_once(-1, T, 9);

    // Tie: 7, 7, 3 keeps class 0.
    set_rows('{7, 0, 0, 0}, '{3, 4, 0, 0}, '{3, 0, 0, 0});
    run_once(-1, -1, 0);

    // Abort during class 1 FETCH keeps the class-0 result.
    set_rows('{5, 0, 0, 0}, '{2, 3, 4, 0}, '{1, 1, 0, 0});
    run_once(7, -1, 0);
    repeat (3) @(negedge clk);
    check("abort_idle", int'(busy), 0);

    // Reset mid-run clears everything without a clock edge.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_rd_en", int'(rd_en), 0);
    check("mrst_acc_en", int'(acc_en), 0);
    check("mrst_rd_class", int'(rd_class), 0);
    check("mrst_rd_chunk", int'(rd_chunk), 0);
    check("mrst_chunk_idx", int'(chunk_idx), 0);
    check("mrst_pred", int'(pred_class), 0);
    check("mrst_best", int'(best_score), 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_stay_idle", int'(busy), 0);

    // Randomised runs: random contents, occasional ties, aborts and stray starts.
    for (int r = 0; r < 20; r++) begin
      int ab, rs;
      for (int i = 0; i < NC; i++)
        for (int j = 0; j < NCH; j++) mem[i][j] = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < NCH; j++) mem[2][j] = mem[0][j];
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T - 1)) : -1;
      rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T)) : -1;
      ref_best(NC, p, b);
      run_once(ab, rs, b + int'($urandom_range(0, 2)) - 1);
      repeat (2) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
